timer_cnt_ctrl: RTL and testbench
=================================

# timer_cnt_ctrl

Sequencing controller for the APB timer's 64-bit counter datapath. Its inputs are the control fields decoded by the register bank (`timer_en`, `div_en`, `div_val`, `halt_req`), the TDR write strobes and the APB write data. It runs the prescaler, the run/halt state machine and the counter update. It drives `cnt_value` back to the register bank, which mirrors it into TDR0/TDR1 and compares it against TCMP. It also drives `halt_ack`, which is reported in THCSR.

## Interface
Parameters:
- `CNT_W`, 64: counter width; must be 64, split over two 32-bit data registers.
- `DIV_W`, 4: width of `div_val`.
- `DIV_MAX`, 8: largest legal prescaler exponent.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst_n`  in  1: reset, synchronous, active-low.
- `timer_en`  in  1: counting enable from TCR.
- `div_en`  in  1: prescaler enable from TCR.
- `div_val`  in  4: prescaler exponent from TCR; divide ratio is 2^div_val.
- `halt_req`  in  1: debug halt request from THCSR.
- `dbg_mode`  in  1: debug mode indicator; a halt is honoured only while this is 1.
- `tdr0_wr_sel`  in  1: write strobe for the low 32-bit counter word.
- `tdr1_wr_sel`  in  1: write strobe for the high 32-bit counter word.
- `wdata`  in  32: APB write data.
- `pstrb`  in  4: APB byte strobes.
- `cnt_value`  out  64: current counter value.
- `cnt_tick`  out  1: one-cycle pulse, high in each cycle the counter increments.
- `halt_ack`  out  1: high while the counter is halted.

## Operation
- **Reset** (`rst_n`=0 at a clk edge): state=IDLE, `cnt_value`=0, prescaler count=0, `timer_en_q`=0, `halt_ack`=0, `cnt_tick`=0.
- **State machine** (next state evaluated every edge):
  - `halt_c` = `halt_req` & `dbg_mode`.
  - IDLE→RUN when `timer_en` & !`halt_c`.
  - IDLE→HALT and RUN→HALT when `halt_c`.
  - RUN→IDLE when !`timer_en`.
  - HALT exits when !`halt_c`: to RUN if `timer_en`, otherwise to IDLE.
- **Prescaler**:
  - Limit L = 2^min(`div_val`, DIV_MAX) − 1 when `div_en`=1, otherwise L=0.
  - `div_val` values above 8 are clamped to 8.
  - Prescaler counts only in RUN with !`halt_c`.
  - Tick occurs when prescaler count ≥ L; the prescaler count then returns to 0.
  - Otherwise the prescaler count increments by 1.
  - Using ≥ covers L shrinking mid-count.
  - In IDLE and HALT the prescaler count holds.
- **Counter increment**:
  - On a tick, `cnt_value` increments by 1.
  - Wrap-around: all-ones→0 with no flag; the register bank compare handles the match.
- **Disable clear**:
  - `timer_en_q` is `timer_en` registered.
  - `clr` = `timer_en_q` & !`timer_en`, i.e. a falling edge of `timer_en` in any state, including HALT.
  - `clr` zeros the counter and the prescaler count on that edge.
- **Software write**:
  - `tdrN_wr_sel` replaces the bytes of the addressed word whose `pstrb` bit is 1 with the corresponding `wdata` bytes.
  - Unstrobed bytes keep their base value.
  - Any TDR write also zeros the prescaler count.
  - Writes take effect in every state, including HALT.
- **Priority in one cycle**:
  - Base value = 0 if `clr`, else `cnt_value`.
  - Write byte-merge is applied on top of the base value.
  - Increment is suppressed in any cycle with `clr` or a TDR write.
  - `tdr0_wr_sel` and `tdr1_wr_sel` both high: both words are merged.

## Timing
- `cnt_tick` is registered. It is high in the cycle after the edge that incremented `cnt_value`, aligned with the new value.
- With `div_en`=0: the first increment happens on the second edge after `timer_en` rises; one edge is spent in IDLE→RUN. After that the counter increments every cycle.
- With `div_en`=1 and `div_val`=k, steady state: one increment every 2^k cycles.
- `halt_c` freezes counting combinationally from the cycle it rises; no increment happens on that edge.
- `halt_ack` = (state==HALT), registered, so it is high one cycle after `halt_c` rises.
- `halt_ack` falls one cycle after `halt_c` falls.
- Counting resumes on the edge after the exit from HALT.
- A TDR write is visible on `cnt_value` one cycle after the write cycle, matching the register bank's TDR update.
- A reset asserted mid-operation overrides everything at that edge.

## Structure
- Package `timer_pkg`:
  - `cnt_state_t` enum {IDLE, RUN, HALT}.
  - `DIV_MAX`.
  - The TDR word-select constants.
- Sub-module `timer_prescaler`:
  - Inputs: `en`, `clr`, `div_en`, `div_val`.
  - Output: `tick`.
  - Holds the 8-bit prescaler count and the limit clamp.
- `timer_cnt_ctrl` holds the FSM, the byte-merge and the counter register.

## Test plan
- Reset, then `timer_en`=1 with `div_en`=0 for 10 cycles → `cnt_value`=9, 9 `cnt_tick` pulses, `halt_ack`=0.
- `div_en`=1, `div_val`=2, run 16 cycles → exactly 4 increments, spaced 4 cycles apart. Repeat with `div_val`=15 → ratio is 256.
- Load TDR1=0xFFFF_FFFF and TDR0=0xFFFF_FFFE with full `pstrb`, then run 3 cycles → `cnt_value` goes …FE→…FF→0x0 wrap→0x1.
- While running, `tdr0_wr_sel` with `pstrb`=4'b0010 and `wdata`=0x0000_AB00 → byte 1 = 0xAB, other bytes and TDR1 unchanged, no increment on that edge.
- `halt_req`=1 with `dbg_mode`=1 for 5 cycles → `cnt_value` frozen, `halt_ack` high from the next cycle, resume on release. Same stimulus with `dbg_mode`=0 → no halt.
- Drop `timer_en` during HALT → counter and prescaler zeroed. `timer_en` falling in the same cycle as a TDR0 write with `wdata`=0x5 → `cnt_value`=0x5.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and constants for the timer counter controller.
//                Holds the run/halt state type, the prescaler exponent cap
//                and the bit positions of the two 32-bit TDR words inside the
//                64-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Run/halt sequencing states of the counter datapath.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } cnt_state_t;

  // Largest legal prescaler exponent (divide by 2^8 = 256).
  localparam int DIV_MAX = 8;

  // TDR word-select constants: each data register covers 32 counter bits.
  localparam int TDR_W      = 32;
  localparam int TDR_LO_LSB = 0;   // TDR0 -> cnt_value[31:0]
  localparam int TDR_HI_LSB = 32;  // TDR1 -> cnt_value[63:32]
  localparam int TDR_BYTES  = TDR_W / 8;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Free-running prescaler for the timer counter. Produces a
//                tick when its count reaches the limit 2^min(div_val,DIV_MAX)-1
//                (limit 0 when the prescaler is disabled).
//  Ports       : clk, rst_n    - clock, synchronous active-low reset
//                en            - count this cycle
//                clr           - zero the prescaler count (priority over en)
//                div_en        - prescaler enable
//                div_val       - prescaler exponent, clamped to DIV_MAX
//                tick          - combinational tick, valid only while en=1
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
  parameter int DIV_W   = 4,
  parameter int DIV_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  // Count width is chosen so the largest limit 2^DIV_MAX-1 just fits.
  localparam int PRE_W = DIV_MAX;
  localparam logic [DIV_W-1:0] DIV_CAP = DIV_W'(DIV_MAX);

  logic [PRE_W-1:0] pre_cnt;
  logic [DIV_W-1:0] shamt;
  logic [PRE_W:0]   lim_pow;
  logic [PRE_W-1:0] limit;

  always_comb begin
    shamt   = (div_val > DIV_CAP) ? DIV_CAP : div_val;
    lim_pow = (PRE_W+1)'(1) << shamt;
    limit   = div_en ? PRE_W'(lim_pow - (PRE_W+1)'(1)) : '0;
    // ">=" rather than "==" so a limit lowered mid-count still fires
    // instead of letting the count run all the way around.
    tick    = en & (pre_cnt >= limit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/timer_cnt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : timer_cnt_ctrl
//  Description : Sequencing controller for the 64-bit APB timer counter.
//                Runs the IDLE/RUN/HALT state machine, the prescaler and the
//                counter update (increment, disable clear, byte-merged TDR
//                software writes).
//  Ports       : clk, rst_n               - clock, synchronous active-low reset
//                timer_en, div_en, div_val- TCR control fields
//                halt_req, dbg_mode       - debug halt request / debug mode
//                tdr0_wr_sel, tdr1_wr_sel - TDR low/high word write strobes
//                wdata, pstrb             - APB write data and byte strobes
//                cnt_value                - current counter value
//                cnt_tick                 - pulse aligned with each increment
//                halt_ack                 - counter is halted
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_cnt_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int DIV_W   = 4,
  parameter int DIV_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             halt_req,
  input  logic             dbg_mode,
  input  logic             tdr0_wr_sel,
  input  logic             tdr1_wr_sel,
  input  logic [31:0]      wdata,
  input  logic [3:0]       pstrb,
  output logic [CNT_W-1:0] cnt_value,
  output logic             cnt_tick,
  output logic             halt_ack
);

  cnt_state_t       state;
  logic             timer_en_q;
  logic             halt_c;
  logic             clr;
  logic             tdr_wr;
  logic             pre_en;
  logic             tick;
  logic             inc;
  logic [CNT_W-1:0] cnt_next;

  assign halt_c = halt_req & dbg_mode;
  // Falling edge of timer_en, detected in every state including HALT.
  assign clr    = timer_en_q & ~timer_en;
  assign tdr_wr = tdr0_wr_sel | tdr1_wr_sel;
  // halt_c gates counting directly so the edge on which it rises is frozen.
  assign pre_en = (state == RUN) & ~halt_c;
  // A clear or software write owns the counter for that cycle.
  assign inc    = tick & ~clr & ~tdr_wr;

  timer_prescaler #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pre_en),
    .clr     (clr | tdr_wr),
    .div_en  (div_en),
    .div_val (div_val),
    .tick    (tick)
  );

  // Run/halt state machine. halt_ack tracks the state being entered so it
  // rises one cycle after halt_c and falls one cycle after it drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer_en_q <= 1'b0;
      halt_ack   <= 1'b0;
    end else begin
      timer_en_q <= timer_en;
      halt_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (halt_c) begin
            state    <= HALT;
            halt_ack <= 1'b1;
          end else if (timer_en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (halt_c) begin
            state    <= HALT;
            halt_ack <= 1'b1;
          end else if (!timer_en) begin
            state <= IDLE;
          end
        end
        HALT: begin
          if (halt_c) begin
            halt_ack <= 1'b1;
          end else if (timer_en) begin
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Next counter value: base (cleared or held), then byte-merged writes,
  // then the increment when neither a clear nor a write is present.
  always_comb begin
    cnt_next = clr ? '0 : cnt_value;
    for (int b = 0; b < TDR_BYTES; b++) begin
      if (tdr0_wr_sel && pstrb[b]) begin
        cnt_next[TDR_LO_LSB + 8*b +: 8] = wdata[8*b +: 8];
      end
      if (tdr1_wr_sel && pstrb[b]) begin
        cnt_next[TDR_HI_LSB + 8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (inc) begin
      cnt_next = cnt_value + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_value <= '0;
      cnt_tick  <= 1'b0;
    end else begin
      cnt_value <= cnt_next;
      cnt_tick  <= inc;
    end
  end

endmodule : timer_cnt_ctrl
`default_nettype wire

// File: tb/tb_timer_cnt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_cnt_ctrl
//  Description : Self-checking bench for timer_cnt_ctrl. Directed scenarios
//                followed by a randomized phase, all compared every cycle
//                against a behavioural model of the counter rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_cnt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        dbg_mode;
  logic        tdr0_wr_sel;
  logic        tdr1_wr_sel;
  logic [31:0] wdata;
  logic [3:0]  pstrb;
  logic [63:0] cnt_value;
  logic        cnt_tick;
  logic        halt_ack;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int dut_ticks;
  int first_tick;
  int last_tick;

  // Behavioural model: counter mode as a plain integer plus arithmetic.
  localparam int M_STOPPED  = 0;
  localparam int M_COUNTING = 1;
  localparam int M_FROZEN   = 2;
  int          m_mode;
  int          m_pre;
  logic [63:0] m_cnt;
  logic        m_en_q;
  logic        m_ack;
  logic        m_tick;

  timer_cnt_ctrl #(
    .CNT_W   (64),
    .DIV_W   (4),
    .DIV_MAX (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .timer_en    (timer_en),
    .div_en      (div_en),
    .div_val     (div_val),
    .halt_req    (halt_req),
    .dbg_mode    (dbg_mode),
    .tdr0_wr_sel (tdr0_wr_sel),
    .tdr1_wr_sel (tdr1_wr_sel),
    .wdata       (wdata),
    .pstrb       (pstrb),
    .cnt_value   (cnt_value),
    .cnt_tick    (cnt_tick),
    .halt_ack    (halt_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs as sampled.
  task automatic model_step();
    bit          halt;
    bit          clr;
    bit          wr;
    bit          counting;
    bit          fire;
    int          limit;
    int          k;
    logic [63:0] nv;
    if (!rst_n) begin
      m_mode = M_STOPPED; m_pre = 0; m_cnt = '0;
      m_en_q = 1'b0; m_ack = 1'b0; m_tick = 1'b0;
      return;
    end
    halt     = halt_req && dbg_mode;
    clr      = m_en_q && !timer_en;
    wr       = tdr0_wr_sel || tdr1_wr_sel;
    k        = (int'(div_val) > 8) ? 8 : int'(div_val);
    limit    = div_en ? (2 ** k) - 1 : 0;
    counting = (m_mode == M_COUNTING) && !halt;
    fire     = counting && (m_pre >= limit);

    nv = clr ? 64'd0 : m_cnt;
    for (int b = 0; b < 4; b++) begin
      if (tdr0_wr_sel && pstrb[b]) nv[8*b +: 8]      = wdata[8*b +: 8];
      if (tdr1_wr_sel && pstrb[b]) nv[32 + 8*b +: 8] = wdata[8*b +: 8];
    end
    m_tick = fire && !clr && !wr;
    if (m_tick) nv = m_cnt + 64'd1;
    m_cnt = nv;

    if (clr || wr)     m_pre = 0;
    else if (counting) m_pre = fire ? 0 : m_pre + 1;

    if (halt)          m_mode = M_FROZEN;
    else if (timer_en) m_mode = M_COUNTING;
    else               m_mode = M_STOPPED;
    m_ack  = (m_mode == M_FROZEN);
    m_en_q = timer_en;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    cycle++;
    #1;
    chk("cnt_value", cnt_value, m_cnt);
    chk("cnt_tick", 64'(cnt_tick), 64'(m_tick));
    chk("halt_ack", 64'(halt_ack), 64'(m_ack));
    if (cnt_tick) begin
      dut_ticks++;
      if (first_tick < 0) first_tick = cycle;
      last_tick = cycle;
    end
  endtask

  initial begin
    rst_n = 1'b0; timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0;
    halt_req = 1'b0; dbg_mode = 1'b0; tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0;
    wdata = '0; pstrb = '0;
    m_mode = M_STOPPED; m_pre = 0; m_cnt = 'x; m_en_q = 1'b0; m_ack = 1'b0; m_tick = 1'b0;
    dut_ticks = 0; first_tick = -1; last_tick = -1;

    // Reset state
    repeat (2) step();
    chk("rst_cnt", cnt_value, 64'd0);
    chk("rst_ack", 64'(halt_ack), 64'd0);
    chk("rst_tick", 64'(cnt_tick), 64'd0);
    rst_n = 1'b1;
    step();

    // Undivided counting: 10 cycles -> value 9, 9 pulses
    timer_en = 1'b1; dut_ticks = 0;
    repeat (10) step();
    chk("run10_cnt", cnt_value, 64'd9);
    chk("run10_ticks", 64'(dut_ticks), 64'd9);
    chk("run10_ack", 64'(halt_ack), 64'd0);

    // Disable clear, then divide by 4
    timer_en = 1'b0; step();
    chk("dis_clr", cnt_value, 64'd0);
    div_en = 1'b1; div_val = 4'd2; timer_en = 1'b1; step();
    dut_ticks = 0; first_tick = -1;
    repeat (16) step();
    chk("div4_ticks", 64'(dut_ticks), 64'd4);
    chk("div4_spacing", 64'(last_tick - first_tick), 64'd12);
    chk("div4_cnt", cnt_value, 64'd4);

    // div_val 15 clamps to ratio 256
    timer_en = 1'b0; step();
    div_val = 4'd15; timer_en = 1'b1; step();
    dut_ticks = 0; first_tick = -1;
    repeat (512) step();
    chk("div256_ticks", 64'(dut_ticks), 64'd2);
    chk("div256_spacing", 64'(last_tick - first_tick), 64'd256);

    // Wrap-around through full-strobe TDR loads
    div_en = 1'b0; pstrb = 4'hF;
    tdr1_wr_sel = 1'b1; wdata = 32'hFFFF_FFFF; step();
    tdr1_wr_sel = 1'b0; tdr0_wr_sel = 1'b1; wdata = 32'hFFFF_FFFE; step();
    tdr0_wr_sel = 1'b0;
    chk("load_fe", cnt_value, 64'hFFFF_FFFF_FFFF_FFFE);
    step(); chk("wrap_ff", cnt_value, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); chk("wrap_0", cnt_value, 64'd0);
    step(); chk("wrap_1", cnt_value, 64'd1);

    // Partial byte write while running: byte 1 only, no increment
    tdr0_wr_sel = 1'b1; pstrb = 4'b0010; wdata = 32'h0000_AB00; step();
    tdr0_wr_sel = 1'b0;
    chk("byte_wr", cnt_value, 64'h0000_0000_0000_AB01);
    step(); chk("byte_wr_next", cnt_value, 64'h0000_0000_0000_AB02);

    // Debug halt honoured
    halt_req = 1'b1; dbg_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_frozen", cnt_value, 64'h0000_0000_0000_AB02);
      chk("halt_ack_hi", 64'(halt_ack), 64'd1);
    end
    halt_req = 1'b0; step();
    chk("halt_exit_ack", 64'(halt_ack), 64'd0);
    chk("halt_exit_cnt", cnt_value, 64'h0000_0000_0000_AB02);
    step(); chk("halt_resume", cnt_value, 64'h0000_0000_0000_AB03);

    // Halt ignored outside debug mode
    halt_req = 1'b1; dbg_mode = 1'b0;
    repeat (5) step();
    chk("nodbg_cnt", cnt_value, 64'h0000_0000_0000_AB08);
    chk("nodbg_ack", 64'(halt_ack), 64'd0);
    halt_req = 1'b0;

    // Disable during HALT clears the counter
    halt_req = 1'b1; dbg_mode = 1'b1; step(); step();
    timer_en = 1'b0; step();
    chk("halt_dis_clr", cnt_value, 64'd0);
    chk("halt_dis_ack", 64'(halt_ack), 64'd1);
    halt_req = 1'b0; step();
    timer_en = 1'b1; step(); step();

    // Clear and TDR0 write together: write wins over the cleared base
    timer_en = 1'b0; tdr0_wr_sel = 1'b1; pstrb = 4'hF; wdata = 32'h0000_0005; step();
    tdr0_wr_sel = 1'b0;
    chk("clr_wr", cnt_value, 64'd5);

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 10) timer_en = ~timer_en;
      if ($urandom_range(0, 99) < 8)  halt_req = ~halt_req;
      if ($urandom_range(0, 99) < 5)  dbg_mode = ~dbg_mode;
      if ($urandom_range(0, 99) < 3)  div_en = ~div_en;
      if ($urandom_range(0, 99) < 5)  div_val = 4'($urandom_range(0, 15));
      tdr0_wr_sel = ($urandom_range(0, 99) < 4);
      tdr1_wr_sel = ($urandom_range(0, 99) < 4);
      wdata = $urandom;
      pstrb = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_timer_cnt_ctrl
`default_nettype wire
